// File: rtl/circuito_pkg.sv
// Shared types and constants for the circuito UART-to-hex-display block.
// Holds the receiver FSM state type, the default bit period and the seven-segment table.
`timescale 1ns/1ps
package circuito_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_CLEANUP
  } rx_state_t;

  // 50 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Active-low segment codes, bit6..bit0 = g..a, indexed by hex digit
  localparam logic [6:0] SEG_CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/rx_serial_8n1.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, LSB-first shift register.
// byte_vld_o pulses for one cycle at the stop-bit sample, with the stop bit value alongside.
`timescale 1ns/1ps
module rx_serial_8n1
  import circuito_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_dat_o,
  output logic       stop_bit_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  rx_state_t       state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  // Synchronizer resets to idle-high so reset release never looks like a start bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q != FULL_CNT) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q != FULL_CNT) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = ST_CLEANUP;
        end
      end
      ST_CLEANUP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_vld_o = 1'b0;
    byte_dat_o = shift_q;
    stop_bit_o = rx_s;
    if (state_q == ST_STOP && cnt_q == FULL_CNT) byte_vld_o = 1'b1;
  end

endmodule

// File: rtl/circuito.sv
// UART 8N1 byte receiver driving a registered active-low hex digit (low nibble of last byte).
// Define CIRCUITO_FRAME_CHECK_EN to drop bytes whose stop bit samples 0.
`timescale 1ns/1ps
module circuito
  import circuito_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] hexa
);

  logic       rx_vld;
  logic [7:0] rx_dat;
  logic       rx_stop;
  logic       disp_we;
  logic [7:0] disp_q;
  logic [6:0] hexa_q;
  logic       unused_hi;

  rx_serial_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i      (clock),
    .rst_i      (reset),
    .rx_i       (entrada_serial),
    .byte_vld_o (rx_vld),
    .byte_dat_o (rx_dat),
    .stop_bit_o (rx_stop)
  );

`ifdef CIRCUITO_FRAME_CHECK_EN
  assign disp_we   = rx_vld & rx_stop;
  assign unused_hi = ^disp_q[7:4];
`else
  assign disp_we   = rx_vld;
  assign unused_hi = ^{disp_q[7:4], rx_stop};
`endif

  // Decode reads the already-latched byte, so hexa trails the latch by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_q <= 8'h00;
      hexa_q <= SEG_CODES[0];
    end else begin
      if (disp_we) disp_q <= rx_dat;
      hexa_q <= SEG_CODES[disp_q[3:0]];
    end
  end

  assign hexa = hexa_q;

endmodule

// File: tb/tb_circuito.sv
// Self-checking bench for circuito: serial frames in, hex display code out, against a byte-level model.
`timescale 1ns/1ps
module tb_circuito;

  localparam int CPB = 434;
`ifdef CIRCUITO_FRAME_CHECK_EN
  localparam bit FRAME_CHK = 1'b1;
`else
  localparam bit FRAME_CHK = 1'b0;
`endif

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       entrada_serial = 1'b1;
  logic [6:0] hexa;

  int         n_total = 0;
  int         n_bad = 0;
  logic [7:0] exp_disp = 8'h00;

  circuito #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .hexa           (hexa)
  );

  always #10 clock = ~clock;

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: hexa=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge that ends the interval
  task automatic hold_line(input logic v, input int n);
    entrada_serial = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input string tag);
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
    check_val({tag, "_pre"}, hexa, SEG_REF[exp_disp[3:0]]);
    hold_line(stop_v, CPB);
    if (stop_v || !FRAME_CHK) exp_disp = b;
    check_val(tag, hexa, SEG_REF[exp_disp[3:0]]);
  endtask

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;

    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (10) @(negedge clock);
    check_val("rst_hexa", hexa, SEG_REF[0]);
    reset = 1'b0;
    hold_line(1'b1, 500);
    check_val("idle_hexa", hexa, SEG_REF[exp_disp[3:0]]);

    for (int v = 1; v <= 9; v++) begin
      send_frame(8'(v), 1'b1, $sformatf("dig%0d", v));
      hold_line(1'b1, 50);
    end

    send_frame(8'h3C, 1'b1, "x3C");
    hold_line(1'b1, 50);

    hold_line(1'b0, 100);
    hold_line(1'b1, 600);
    check_val("glitch", hexa, SEG_REF[exp_disp[3:0]]);

    send_frame(8'h05, 1'b0, "badstop");
    hold_line(1'b1, 600);
    check_val("badstop_idle", hexa, SEG_REF[exp_disp[3:0]]);

    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b1[3:0] = 4'($urandom_range(1, 15));
    send_frame(b0, 1'b1, "b2b_0");
    send_frame(b1, 1'b1, "b2b_1");
    hold_line(1'b1, $urandom_range(20, 80));

    // 0x07 aborted by reset in the middle of data bit 4
    hold_line(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_line(1'b1 & (i < 3), CPB);
    hold_line(1'b0, CPB / 2);
    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    exp_disp = 8'h00;
    hold_line(1'b1, 100);
    check_val("rst_mid", hexa, SEG_REF[exp_disp[3:0]]);

    send_frame(8'h02, 1'b1, "after_rst");
    hold_line(1'b1, 50);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "time limit");
  end

endmodule
